mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer that shares the single AXI block port between three cache requesters: instruction-cache refill, data-cache refill and data-cache dirty writeback. It sits between the cache FSM/datapath and the AXI master. It picks one request, issues a one-cycle read or write start with a block-aligned address, and holds address and write data stable until `i_axi_done`. It then returns the captured read block and a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, byte address width.
- `BLOCK_WIDTH`, 512, cache block / AXI burst payload width in bits.

Ports:
- Reset is synchronous and active-high.
- `i_clk`  in  1  clock.
- `i_arst`  in  1  synchronous active-high reset.
- `i_req_i`  in  1  icache refill request, level, held until `o_ack_i`.
- `i_addr_i`  in  ADDR_WIDTH  icache miss address.
- `i_req_d`  in  1  dcache refill request, level, held until `o_ack_d`.
- `i_addr_d`  in  ADDR_WIDTH  dcache miss address.
- `i_req_wb`  in  1  dcache writeback request, level, held until `o_ack_wb`.
- `i_addr_wb`  in  ADDR_WIDTH  victim block address.
- `i_wb_block`  in  BLOCK_WIDTH  victim block data.
- `i_axi_done`  in  1  AXI transfer complete, single-cycle pulse.
- `i_data_block`  in  BLOCK_WIDTH  AXI read data, valid with `i_axi_done`.
- `o_axi_addr`  out  ADDR_WIDTH  block-aligned transfer address.
- `o_axi_wdata`  out  BLOCK_WIDTH  write payload.
- `o_axi_read_start`  out  1  read start pulse.
- `o_axi_write_start`  out  1  write start pulse.
- `o_rdata`  out  BLOCK_WIDTH  captured read block for the acked requester.
- `o_ack_i`, `o_ack_d`, `o_ack_wb`  out  1 each  completion pulses.
- `o_busy`  out  1  transfer in flight (any state other than IDLE).

## Operation
- FSM states:
  - IDLE: evaluate requests.
  - START: one cycle; start pulse asserted.
  - WAIT: wait for `i_axi_done`.
  - ACK: one cycle; ack pulse asserted.
- Transitions:
  - IDLE → START when any request is high.
  - START → WAIT unconditionally.
  - WAIT → ACK on `i_axi_done`.
  - ACK → IDLE unconditionally.
- Requests are sampled only in IDLE. Requests are ignored in START, WAIT and ACK.
- Priority:
  - `i_req_wb` wins over both reads, so a dirty victim leaves before its refill.
  - Between `i_req_i` and `i_req_d`, round-robin using a 1-bit `last_read` register: on a tie, grant the requester not granted last.
  - `last_read` updates only on read grants. Its reset value is I, so D wins the first tie.
- On grant (IDLE→START edge), latch the grantee id and the address.
  - `o_axi_addr` = address with the low `$clog2(BLOCK_WIDTH/8)` bits forced to 0 (6 bits at default).
  - For a writeback grant, also latch `i_wb_block` into `o_axi_wdata`.
- `o_axi_addr` and `o_axi_wdata` hold from the START cycle through the ACK cycle.
- In WAIT, on `i_axi_done`:
  - for a read, capture `i_data_block` into `o_rdata`;
  - for a writeback, leave `o_rdata` unchanged.
- A requester sees its ack in the ACK cycle and must deassert its request at the next edge. The IDLE state that follows must not see a stale request.
- A request may be dropped while IDLE without side effects, e.g. icache refill cancelled by a branch mispredict before grant. After grant, the transfer always completes.
- `i_axi_done` outside WAIT is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - FSM state IDLE, `last_read` = I.
  - `o_axi_addr` = 0, `o_axi_wdata` = 0, `o_rdata` = 0.
  - All starts, acks and `o_busy` = 0.
- Reset asserted in any state returns to IDLE at the next edge. The in-flight transfer is abandoned and no ack is produced; the AXI master shares the reset.
- Request high in IDLE at edge N:
  - START state and the start pulse during cycle N+1 to N+2.
  - `o_busy` high from N+1.
- `i_axi_done` sampled at edge M in WAIT: the ack pulse and `o_rdata` are valid during cycle M+1 to M+2.
- IDLE is re-entered at M+2.
- Minimum occupancy is 4 cycles (done arriving in the first WAIT cycle). Back-to-back grants are separated by exactly one IDLE cycle.
- Exactly one of `o_axi_read_start` / `o_axi_write_start` per grant. At most one ack is high in any cycle.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, START, WAIT, ACK};
  - `req_id_t` enum {REQ_I, REQ_D, REQ_WB};
  - localparam `BLOCK_OFFSET_W` = `$clog2(BLOCK_WIDTH/8)`.
- One sub-module `mem_arb_pick`: combinational priority + round-robin select taking the three requests and `last_read`, returning a valid flag and a `req_id_t`.
- FSM and registers stay in `mem_arbiter`.

## Test plan
- Reset then idle: all outputs 0, `o_busy` 0, for 10 cycles with no requests.
- `i_req_d` with `i_addr_d` = 0x8000_1234, done after 5 WAIT cycles with `i_data_block` = pattern A:
  - one read pulse with `o_axi_addr` = 0x8000_1200;
  - `o_ack_d` one cycle, `o_rdata` = A;
  - no writes.
- `i_req_wb` (0x4000_0040, block B) and `i_req_d` asserted together:
  - write start first, `o_axi_wdata` = B, `o_ack_wb`;
  - after one IDLE cycle, read start for D.
- `i_req_i` and `i_req_d` held continuously, each acked and re-raised:
  - grants alternate D, I, D, I;
  - no requester is granted twice consecutively.
- `i_arst` pulsed during WAIT of an icache refill:
  - IDLE next cycle, no `o_ack_i`, outputs at reset values;
  - a late `i_axi_done` is ignored.
- `i_axi_done` pulsed while IDLE or START:
  - no state change, no ack;
  - transfer completes only on a done in WAIT.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the cache-to-AXI block arbiter.
//   state_t        - arbiter FSM states
//   req_id_t       - identity of the granted requester
//   BLOCK_OFFSET_W - byte-offset bits inside a block at the default 512-bit block
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;
  typedef enum logic [1:0] {REQ_I, REQ_D, REQ_WB} req_id_t;

  localparam int BLOCK_WIDTH_DEF = 512;
  localparam int BLOCK_OFFSET_W  = $clog2(BLOCK_WIDTH_DEF / 8);

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant select for the three cache requesters.
//   req_icache_i / req_dcache_i / req_wb_i - request levels
//   last_d_i - 1 when the previous read grant went to the dcache
//   vld_o    - some request is pending
//   id_o     - winner: writeback first, then round-robin between the reads
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    req_icache_i,
  input  logic    req_dcache_i,
  input  logic    req_wb_i,
  input  logic    last_d_i,
  output logic    vld_o,
  output req_id_t id_o
);

  always_comb begin
    vld_o = req_icache_i | req_dcache_i | req_wb_i;
    id_o  = REQ_I;
    // Writeback first so a dirty victim leaves before the refill that replaces it.
    if (req_wb_i)                        id_o = REQ_WB;
    else if (req_icache_i && req_dcache_i) id_o = last_d_i ? REQ_I : REQ_D;
    else if (req_dcache_i)               id_o = REQ_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI block port between icache refill, dcache refill
// and dcache writeback.
//   i_req_* / i_addr_*      - level requests with their byte addresses
//   i_wb_block              - victim data for the writeback requester
//   i_axi_done/i_data_block - transfer completion and read data from AXI
//   o_axi_*                 - block-aligned address, write data, start pulses
//   o_rdata, o_ack_*        - read block and completion pulse to the winner
//   o_busy                  - high in every state except IDLE
// All outputs are registered; reset is synchronous active-high.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_req_i,
  input  logic [ADDR_WIDTH-1:0]  i_addr_i,
  input  logic                   i_req_d,
  input  logic [ADDR_WIDTH-1:0]  i_addr_d,
  input  logic                   i_req_wb,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic [BLOCK_WIDTH-1:0] i_wb_block,
  input  logic                   i_axi_done,
  input  logic [BLOCK_WIDTH-1:0] i_data_block,
  output logic [ADDR_WIDTH-1:0]  o_axi_addr,
  output logic [BLOCK_WIDTH-1:0] o_axi_wdata,
  output logic                   o_axi_read_start,
  output logic                   o_axi_write_start,
  output logic [BLOCK_WIDTH-1:0] o_rdata,
  output logic                   o_ack_i,
  output logic                   o_ack_d,
  output logic                   o_ack_wb,
  output logic                   o_busy
);

  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  state_t                  state_q;
  req_id_t                 id_q;
  logic                    last_d_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BLOCK_WIDTH-1:0]  wdata_q, rdata_q;
  logic                    rd_start_q, wr_start_q, ack_i_q, ack_d_q, ack_wb_q, busy_q;

  logic                    pick_vld;
  req_id_t                 pick_id;
  logic [ADDR_WIDTH-1:0]   addr_d;

  mem_arb_pick u_pick (
    .req_icache_i (i_req_i),
    .req_dcache_i (i_req_d),
    .req_wb_i     (i_req_wb),
    .last_d_i     (last_d_q),
    .vld_o        (pick_vld),
    .id_o         (pick_id)
  );

  always_comb begin
    addr_d = i_addr_i;
    if (pick_id == REQ_D)       addr_d = i_addr_d;
    else if (pick_id == REQ_WB) addr_d = i_addr_wb;
    addr_d = addr_d & ALIGN_MASK;
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q    <= IDLE;
      id_q       <= REQ_I;
      last_d_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      ack_i_q    <= 1'b0;
      ack_d_q    <= 1'b0;
      ack_wb_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // Start and ack are single-cycle pulses; only the transitions below raise them.
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      ack_i_q    <= 1'b0;
      ack_d_q    <= 1'b0;
      ack_wb_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= START;
            busy_q  <= 1'b1;
            id_q    <= pick_id;
            addr_q  <= addr_d;
            if (pick_id == REQ_WB) begin
              wr_start_q <= 1'b1;
              wdata_q    <= i_wb_block;
            end else begin
              rd_start_q <= 1'b1;
              // Round-robin memory is touched only by read grants.
              last_d_q   <= (pick_id == REQ_D);
            end
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (i_axi_done) begin
            state_q <= ACK;
            if (id_q == REQ_WB) begin
              ack_wb_q <= 1'b1;
            end else begin
              rdata_q <= i_data_block;
              if (id_q == REQ_D) ack_d_q <= 1'b1;
              else               ack_i_q <= 1'b1;
            end
          end
        end
        ACK: begin
          // The acked requester drops its level at this edge, so IDLE never sees it stale.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_axi_addr        = addr_q;
  assign o_axi_wdata       = wdata_q;
  assign o_axi_read_start  = rd_start_q;
  assign o_axi_write_start = wr_start_q;
  assign o_rdata           = rdata_q;
  assign o_ack_i           = ack_i_q;
  assign o_ack_d           = ack_d_q;
  assign o_ack_wb          = ack_wb_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Table-driven grant
// vectors, hand sequences for reset/done corner cases, and randomized
// request traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int BW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst, req_i, req_d, req_wb, axi_done;
  logic [AW-1:0] addr_i, addr_d, addr_wb;
  logic [BW-1:0] wb_block, data_block;
  logic [AW-1:0] o_axi_addr;
  logic [BW-1:0] o_axi_wdata, o_rdata;
  logic o_axi_read_start, o_axi_write_start, o_ack_i, o_ack_d, o_ack_wb, o_busy;

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_req_i(req_i), .i_addr_i(addr_i),
    .i_req_d(req_d), .i_addr_d(addr_d),
    .i_req_wb(req_wb), .i_addr_wb(addr_wb), .i_wb_block(wb_block),
    .i_axi_done(axi_done), .i_data_block(data_block),
    .o_axi_addr(o_axi_addr), .o_axi_wdata(o_axi_wdata),
    .o_axi_read_start(o_axi_read_start), .o_axi_write_start(o_axi_write_start),
    .o_rdata(o_rdata), .o_ack_i(o_ack_i), .o_ack_d(o_ack_d), .o_ack_wb(o_ack_wb),
    .o_busy(o_busy)
  );

  int vecs = 0;
  int errs = 0;
  // Model state: which read requester was served last (0 = I, 1 = D) and the last read block.
  int model_last = 0;
  logic [BW-1:0] model_rdata = '0;
  int gap;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  // 0 = I, 1 = D, 2 = WB
  function automatic int model_pick(logic ri, logic rd, logic rw, int last);
    if (rw) return 2;
    if (ri && rd) return (last == 0) ? 1 : 0;
    if (rd) return 1;
    return 0;
  endfunction

  function automatic logic [BW-1:0] rnd_blk();
    logic [BW-1:0] b;
    for (int w = 0; w < BW/32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  always @(negedge clk) begin
    chk("ack_onehot", ($countones({o_ack_i, o_ack_d, o_ack_wb}) <= 1), 1'b1);
    chk("start_excl", !(o_axi_read_start && o_axi_write_start), 1'b1);
  end

  task automatic do_reset();
    @(negedge clk) arst = 1'b1;
    req_i = 0; req_d = 0; req_wb = 0; axi_done = 0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    model_last = 0;
    model_rdata = '0;
  endtask

  // One full transaction from an IDLE negedge; requests must already be set.
  task automatic do_txn(input int dly, output int gid, output logic [AW-1:0] gaddr);
    int expv, n;
    logic [AW-1:0] ea;
    logic [BW-1:0] rb;
    expv = model_pick(req_i, req_d, req_wb, model_last);
    ea = (expv == 2) ? addr_wb : (expv == 1) ? addr_d : addr_i;
    ea[5:0] = '0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(o_axi_read_start || o_axi_write_start) && n < 20);
    gap = n;
    chk("start_seen", o_axi_read_start | o_axi_write_start, 1'b1);
    chk("write_start", o_axi_write_start, expv == 2);
    chk("read_start", o_axi_read_start, expv != 2);
    chk("axi_addr", o_axi_addr, ea);
    chk("busy_start", o_busy, 1'b1);
    if (expv == 2) chk("axi_wdata", o_axi_wdata, wb_block);
    else model_last = expv;
    gaddr = o_axi_addr;
    @(negedge clk);
    chk("start_pulse_len", {o_axi_read_start, o_axi_write_start}, 2'b00);
    for (int k = 0; k < dly; k++) begin
      chk("no_early_ack", {o_ack_i, o_ack_d, o_ack_wb}, 3'b000);
      @(negedge clk);
    end
    rb = rnd_blk();
    data_block = rb;
    axi_done = 1'b1;
    @(posedge clk) #1;
    axi_done = 1'b0;
    data_block = rnd_blk();
    @(negedge clk);
    gid = o_ack_wb ? 2 : o_ack_d ? 1 : o_ack_i ? 0 : -1;
    chk("ack_id", gid, expv);
    if (expv != 2) model_rdata = rb;
    chk("rdata", o_rdata, model_rdata);
    chk("addr_hold", o_axi_addr, ea);
    @(posedge clk) #1;
    if (expv == 0) req_i = 1'b0;
    else if (expv == 1) req_d = 1'b0;
    else req_wb = 1'b0;
    @(negedge clk);
    chk("idle_busy", o_busy, 1'b0);
    chk("idle_ack", {o_ack_i, o_ack_d, o_ack_wb}, 3'b000);
  endtask

  typedef struct {
    logic ri, rd, rw;
    logic [AW-1:0] ai, ad, aw;
    int dly;
    int exp_id;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid;
    logic [AW-1:0] ga;
    logic [BW-1:0] rb;

    tbl[0] = '{0,1,0, 64'h0, 64'h8000_1234, 64'h0, 5, 1, 64'h8000_1200};
    tbl[1] = '{1,1,0, 64'h1000_0080, 64'h2000_00C5, 64'h0, 0, 0, 64'h1000_0080};
    tbl[2] = '{1,1,0, 64'h1111_1111, 64'h2222_2222, 64'h0, 1, 1, 64'h2222_2200};
    tbl[3] = '{1,1,1, 64'h1, 64'h2, 64'h4000_0040, 2, 2, 64'h4000_0040};
    tbl[4] = '{1,1,0, 64'h3000_007F, 64'h5000_0000, 64'h0, 0, 0, 64'h3000_0040};
    tbl[5] = '{1,0,0, 64'hDEAD_BEEF, 64'h0, 64'h0, 3, 0, 64'hDEAD_BEC0};
    tbl[6] = '{1,1,0, 64'h0, 64'h123, 64'h0, 0, 1, 64'h100};
    tbl[7] = '{0,0,1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 64'hFFFF_FFFF_FFFF_FFC0};
    tbl[8] = '{0,1,0, 64'h0, 64'h3F, 64'h0, 0, 1, 64'h0};

    arst = 1; req_i = 0; req_d = 0; req_wb = 0; axi_done = 0;
    addr_i = '0; addr_d = '0; addr_wb = '0; wb_block = '0; data_block = '0;
    do_reset();

    // Idle after reset: nothing moves for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("reset_ctrl", {o_axi_read_start, o_axi_write_start, o_ack_i, o_ack_d, o_ack_wb, o_busy}, 6'b0);
    end
    chk("reset_addr", o_axi_addr, '0);
    chk("reset_wdata", o_axi_wdata, '0);
    chk("reset_rdata", o_rdata, '0);

    // Grant vectors; losers are dropped in IDLE between rows.
    foreach (tbl[v]) begin
      req_i = tbl[v].ri; req_d = tbl[v].rd; req_wb = tbl[v].rw;
      addr_i = tbl[v].ai; addr_d = tbl[v].ad; addr_wb = tbl[v].aw;
      wb_block = rnd_blk();
      do_txn(tbl[v].dly, gid, ga);
      chk("tbl_id", gid, tbl[v].exp_id);
      chk("tbl_addr", ga, tbl[v].exp_addr);
      req_i = 0; req_d = 0; req_wb = 0;
    end

    // Writeback and dcache refill together: write first, then read after one IDLE cycle.
    req_wb = 1; addr_wb = 64'h4000_0040; wb_block = {16{32'hB0B0_5A5A}};
    req_d = 1; addr_d = 64'h0000_0000_0BAD_F00D;
    do_txn(2, gid, ga);
    chk("wbd_first", gid, 2);
    do_txn(1, gid, ga);
    chk("wbd_second", gid, 1);
    chk("b2b_gap", gap, 1);

    // Both reads held and re-raised: D, I, D, I from reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_i = 1; req_d = 1;
      addr_i = {$urandom, $urandom}; addr_d = {$urandom, $urandom};
      do_txn(k, gid, ga);
      chk("alt_grant", gid, (k % 2 == 0) ? 1 : 0);
    end
    req_i = 0; req_d = 0;

    // Reset during WAIT of an icache refill abandons the transfer.
    req_i = 1; addr_i = 64'h7777_7777;
    for (int n = 0; n < 20 && !o_axi_read_start; n++) @(negedge clk);
    chk("rstwait_start", o_axi_read_start, 1'b1);
    repeat (2) @(negedge clk);
    arst = 1; req_i = 0;
    @(negedge clk);
    arst = 0;
    model_last = 0; model_rdata = '0;
    chk("rstwait_ctrl", {o_axi_read_start, o_axi_write_start, o_ack_i, o_ack_d, o_ack_wb, o_busy}, 6'b0);
    chk("rstwait_addr", o_axi_addr, '0);
    chk("rstwait_wdata", o_axi_wdata, '0);
    chk("rstwait_rdata", o_rdata, '0);
    axi_done = 1;
    @(negedge clk) axi_done = 0;
    chk("late_done", {o_ack_i, o_ack_d, o_ack_wb, o_busy}, 4'b0);

    // Done while IDLE and while START is ignored.
    axi_done = 1;
    @(negedge clk) axi_done = 0;
    chk("idle_done", {o_ack_i, o_ack_d, o_ack_wb, o_busy}, 4'b0);
    req_d = 1; addr_d = 64'h1234_5678_9ABC_DEF0; axi_done = 1;
    @(negedge clk);
    chk("sd_start", {o_axi_read_start, o_busy}, 2'b11);
    @(negedge clk);
    axi_done = 0;
    chk("sd_noack1", {o_ack_i, o_ack_d, o_ack_wb}, 3'b0);
    @(negedge clk);
    chk("sd_noack2", {o_ack_i, o_ack_d, o_ack_wb, o_busy}, 4'b0001);
    rb = rnd_blk(); data_block = rb; axi_done = 1;
    @(negedge clk);
    axi_done = 0; req_d = 0;
    chk("sd_ack", {o_ack_i, o_ack_d, o_ack_wb}, 3'b010);
    chk("sd_rdata", o_rdata, rb);
    chk("sd_addr", o_axi_addr, 64'h1234_5678_9ABC_DEC0);
    model_rdata = rb; model_last = 1;
    @(negedge clk);
    chk("sd_idle", o_busy, 1'b0);

    // Random traffic: requests held, dropped in IDLE, or raised between transactions.
    for (int t = 0; t < 40; t++) begin
      if (!req_i && $urandom_range(1) == 1) begin req_i = 1; addr_i = {$urandom, $urandom}; end
      else if (req_i && $urandom_range(3) == 0) req_i = 0;
      if (!req_d && $urandom_range(1) == 1) begin req_d = 1; addr_d = {$urandom, $urandom}; end
      else if (req_d && $urandom_range(3) == 0) req_d = 0;
      if (!req_wb && $urandom_range(2) == 0) begin req_wb = 1; addr_wb = {$urandom, $urandom}; wb_block = rnd_blk(); end
      else if (req_wb && $urandom_range(3) == 0) req_wb = 0;
      if (!(req_i || req_d || req_wb)) begin req_d = 1; addr_d = {$urandom, $urandom}; end
      do_txn($urandom_range(4), gid, ga);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
